// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB sizes and dispatch/retire record types
package reorder_buffer_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int PREG_COUNT = 64;

    typedef struct packed {
        logic valid1;
        logic valid2;
        logic [5:0] destReg1;
        logic [5:0] destReg2;
        logic [5:0] destRegOld1;
        logic [5:0] destRegOld2;
        logic [3:0] robNum1;
        logic [3:0] robNum2;
        logic [31:0] pc1;
        logic [31:0] pc2;
    } robDispatchStruct;

    typedef struct packed {
        logic valid;
        logic [5:0] destReg;
        logic [5:0] oldReg;
        logic [31:0] pc;
    } robRetireStruct;
endpackage

// File: rtl/reorder_buffer_order_fifo.sv
// rob_order_fifo: dual-push/dual-pop 16x4 program-order FIFO of ROB entry indices
module rob_order_fifo
    import reorder_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push0,
    input  logic       push1,
    input  logic [3:0] pushIdx0,
    input  logic [3:0] pushIdx1,
    input  logic [1:0] popCount,
    output logic [3:0] head0,
    output logic [3:0] head1,
    output logic [4:0] count
);
    logic [3:0] mem [ROB_DEPTH];
    logic [3:0] headPtr, tailPtr;

    assign head0 = mem[headPtr];
    assign head1 = mem[headPtr + 4'd1];

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count <= '0;
        end else begin
            if (push0) mem[tailPtr] <= pushIdx0;
            if (push1) mem[tailPtr + 4'(push0)] <= pushIdx1;
            tailPtr <= tailPtr + 4'(push0) + 4'(push1);
            headPtr <= headPtr + 4'(popCount);
            count <= count + 5'(push0) + 5'(push1) - 5'(popCount);
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry dual-dispatch/dual-retire ROB; define ROB_RETIRE_PC_EN to store and retire PCs
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int PREG_COUNT = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  reorder_buffer_pkg::robDispatchStruct robDispatch,
    input  logic [1:0]                           completeValid,
    input  logic [1:0][3:0]                      completeRobNum,
    output logic [ROB_DEPTH-1:0]                 robFree,
    output logic [PREG_COUNT-1:0]                retireRegReady,
    output logic [1:0]                           retireValid,
    output logic [1:0][5:0]                      retireDestReg,
    output logic [1:0][5:0]                      retireOldReg,
    output logic [1:0][31:0]                     retirePc,
    output logic [4:0]                           robCount,
    output logic                                 robError
);
    import reorder_buffer_pkg::*;

    logic [ROB_DEPTH-1:0] busy, done;
    logic [5:0] destMem [ROB_DEPTH];
    logic [5:0] oldMem [ROB_DEPTH];
    logic acc1, acc2, ret0, ret1, dispErr, compErr;
    logic [3:0] head0, head1;
    logic [4:0] fifoCount;
    logic [1:0][31:0] headPc;
    robRetireStruct [1:0] retireQ, retireNext;
    logic [PREG_COUNT-1:0] regReadyNext;

`ifdef ROB_RETIRE_PC_EN
    logic [31:0] pcMem [ROB_DEPTH];
    always_ff @(posedge clk) begin
        if (acc1) pcMem[robDispatch.robNum1] <= robDispatch.pc1;
        if (acc2) pcMem[robDispatch.robNum2] <= robDispatch.pc2;
    end
    assign headPc = {pcMem[head1], pcMem[head0]};
`else
    logic unusedPc;
    assign unusedPc = ^{robDispatch.pc1, robDispatch.pc2};
    assign headPc = '0;
`endif

    // Dispatch only sees registered busy, so entries freed this edge are reusable next cycle
    always_comb begin
        acc1 = robDispatch.valid1 && !busy[robDispatch.robNum1];
        acc2 = robDispatch.valid2 && !busy[robDispatch.robNum2]
            && !(robDispatch.valid1 && robDispatch.robNum1 == robDispatch.robNum2);
        dispErr = (robDispatch.valid1 && !acc1) || (robDispatch.valid2 && !acc2);
        compErr = (completeValid[0] && !busy[completeRobNum[0]])
            || (completeValid[1] && !busy[completeRobNum[1]]);
        ret0 = fifoCount != 5'd0 && done[head0];
        ret1 = ret0 && fifoCount > 5'd1 && done[head1];
        retireNext = '0;
        if (ret0) retireNext[0] = '{1'b1, destMem[head0], oldMem[head0], headPc[0]};
        if (ret1) retireNext[1] = '{1'b1, destMem[head1], oldMem[head1], headPc[1]};
        regReadyNext = '0;
        if (ret0) regReadyNext[destMem[head0]] = 1'b1;
        if (ret1) regReadyNext[destMem[head1]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
            done <= '0;
            retireQ <= '0;
            retireRegReady <= '0;
            robError <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (completeValid[k] && busy[completeRobNum[k]]) done[completeRobNum[k]] <= 1'b1;
            if (ret0) begin
                busy[head0] <= 1'b0;
                done[head0] <= 1'b0;
            end
            if (ret1) begin
                busy[head1] <= 1'b0;
                done[head1] <= 1'b0;
            end
            if (acc1) begin
                busy[robDispatch.robNum1] <= 1'b1;
                done[robDispatch.robNum1] <= 1'b0;
                destMem[robDispatch.robNum1] <= robDispatch.destReg1;
                oldMem[robDispatch.robNum1] <= robDispatch.destRegOld1;
            end
            if (acc2) begin
                busy[robDispatch.robNum2] <= 1'b1;
                done[robDispatch.robNum2] <= 1'b0;
                destMem[robDispatch.robNum2] <= robDispatch.destReg2;
                oldMem[robDispatch.robNum2] <= robDispatch.destRegOld2;
            end
            retireQ <= retireNext;
            retireRegReady <= regReadyNext;
            robError <= robError | dispErr | compErr;
        end
    end

    rob_order_fifo orderFifo (
        .clk(clk),
        .reset(reset),
        .push0(acc1),
        .push1(acc2),
        .pushIdx0(robDispatch.robNum1),
        .pushIdx1(robDispatch.robNum2),
        .popCount(2'(ret0) + 2'(ret1)),
        .head0(head0),
        .head1(head1),
        .count(fifoCount)
    );

    assign robFree = ~busy;
    assign robCount = fifoCount;
    assign retireValid = {retireQ[1].valid, retireQ[0].valid};
    assign retireDestReg = {retireQ[1].destReg, retireQ[0].destReg};
    assign retireOldReg = {retireQ[1].oldReg, retireQ[0].oldReg};
    assign retirePc = {retireQ[1].pc, retireQ[0].pc};
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vector table plus hand sequences for fill/drain and reset corners
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    robDispatchStruct disp;
    logic [1:0] cv;
    logic [1:0][3:0] cn;
    logic [15:0] robFree;
    logic [63:0] retireRegReady;
    logic [1:0] retireValid;
    logic [1:0][5:0] retireDestReg, retireOldReg;
    logic [1:0][31:0] retirePc;
    logic [4:0] robCount;
    logic robError;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic rst;
        logic v1; logic [3:0] n1; logic [5:0] d1;
        logic v2; logic [3:0] n2; logic [5:0] d2;
        logic [1:0] cv; logic [3:0] c0; logic [3:0] c1;
        logic [15:0] eFree; logic [4:0] eCnt; logic [1:0] eRv;
        logic [5:0] eRd0; logic [5:0] eRd1; logic [63:0] eRdy; logic eErr;
    } vecT;
    vecT vecs [22];

    reorder_buffer dut (
        .clk(clk), .reset(reset), .robDispatch(disp),
        .completeValid(cv), .completeRobNum(cn),
        .robFree(robFree), .retireRegReady(retireRegReady), .retireValid(retireValid),
        .retireDestReg(retireDestReg), .retireOldReg(retireOldReg), .retirePc(retirePc),
        .robCount(robCount), .robError(robError)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pcOf(input logic [5:0] d);
        return 32'h40 + {24'd0, d, 2'b00};
    endfunction

    function automatic logic [31:0] expPc(input logic [5:0] d);
`ifdef ROB_RETIRE_PC_EN
        return pcOf(d);
`else
        return 32'd0 & pcOf(d);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setDisp(input logic v1, input logic [3:0] n1, input logic [5:0] d1,
                           input logic v2, input logic [3:0] n2, input logic [5:0] d2);
        disp.valid1 = v1; disp.robNum1 = n1; disp.destReg1 = d1;
        disp.destRegOld1 = d1 ^ 6'h20; disp.pc1 = pcOf(d1);
        disp.valid2 = v2; disp.robNum2 = n2; disp.destReg2 = d2;
        disp.destRegOld2 = d2 ^ 6'h20; disp.pc2 = pcOf(d2);
    endtask

    task automatic idle;
        disp = '0;
        cv = '0;
        cn = '0;
    endtask

    initial begin
        vecs[0]  = '{1, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b00, 0,0, 64'h0, 0};
        vecs[1]  = '{0, 1,15,5, 1,14,6, 2'b00,0,0, 16'h3FFF, 2, 2'b00, 0,0, 64'h0, 0};
        vecs[2]  = '{0, 0,0,0, 0,0,0, 2'b01,14,0, 16'h3FFF, 2, 2'b00, 0,0, 64'h0, 0};
        vecs[3]  = '{0, 0,0,0, 0,0,0, 2'b01,15,0, 16'h3FFF, 2, 2'b00, 0,0, 64'h0, 0};
        vecs[4]  = '{0, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b11, 5,6, 64'h60, 0};
        vecs[5]  = '{0, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b00, 0,0, 64'h0, 0};
        vecs[6]  = '{0, 1,3,0, 1,3,1, 2'b00,0,0,  16'hFFF7, 1, 2'b00, 0,0, 64'h0, 1};
        vecs[7]  = '{0, 0,0,0, 0,0,0, 2'b01,3,0,  16'hFFF7, 1, 2'b00, 0,0, 64'h0, 1};
        vecs[8]  = '{0, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b01, 0,0, 64'h1, 1};
        vecs[9]  = '{1, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b00, 0,0, 64'h0, 0};
        vecs[10] = '{0, 0,0,0, 0,0,0, 2'b10,0,2,  16'hFFFF, 0, 2'b00, 0,0, 64'h0, 1};
        vecs[11] = '{1, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b00, 0,0, 64'h0, 0};
        vecs[12] = '{0, 0,0,0, 1,1,10, 2'b00,0,0, 16'hFFFD, 1, 2'b00, 0,0, 64'h0, 0};
        vecs[13] = '{0, 1,1,11, 1,4,12, 2'b00,0,0, 16'hFFED, 2, 2'b00, 0,0, 64'h0, 1};
        vecs[14] = '{0, 0,0,0, 0,0,0, 2'b11,4,1,  16'hFFED, 2, 2'b00, 0,0, 64'h0, 1};
        vecs[15] = '{0, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b11, 10,12, 64'h1400, 1};
        vecs[16] = '{1, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b00, 0,0, 64'h0, 0};
        vecs[17] = '{0, 1,2,7, 1,5,8, 2'b00,0,0,  16'hFFDB, 2, 2'b00, 0,0, 64'h0, 0};
        vecs[18] = '{0, 0,0,0, 0,0,0, 2'b01,2,0,  16'hFFDB, 2, 2'b00, 0,0, 64'h0, 0};
        vecs[19] = '{0, 0,0,0, 0,0,0, 2'b01,5,0,  16'hFFDF, 1, 2'b01, 7,0, 64'h80, 0};
        vecs[20] = '{0, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b01, 8,0, 64'h100, 0};
        vecs[21] = '{0, 0,0,0, 0,0,0, 2'b00,0,0,  16'hFFFF, 0, 2'b00, 0,0, 64'h0, 0};

        reset = 1'b1;
        idle();
        for (int i = 0; i < 22; i++) begin
            logic [1:0][5:0] rd;
            reset = vecs[i].rst;
            setDisp(vecs[i].v1, vecs[i].n1, vecs[i].d1, vecs[i].v2, vecs[i].n2, vecs[i].d2);
            cv = vecs[i].cv;
            cn = {vecs[i].c1, vecs[i].c0};
            tick();
            rd = {vecs[i].eRd1, vecs[i].eRd0};
            check($sformatf("row%0d free", i), 64'(robFree), 64'(vecs[i].eFree));
            check($sformatf("row%0d count", i), 64'(robCount), 64'(vecs[i].eCnt));
            check($sformatf("row%0d retireValid", i), 64'(retireValid), 64'(vecs[i].eRv));
            check($sformatf("row%0d regReady", i), retireRegReady, vecs[i].eRdy);
            check($sformatf("row%0d robError", i), 64'(robError), 64'(vecs[i].eErr));
            for (int s = 0; s < 2; s++) begin
                check($sformatf("row%0d dest%0d", i, s), 64'(retireDestReg[s]), 64'(rd[s]));
                check($sformatf("row%0d old%0d", i, s), 64'(retireOldReg[s]),
                      64'(vecs[i].eRv[s] ? rd[s] ^ 6'h20 : 6'h0));
                check($sformatf("row%0d pc%0d", i, s), 64'(retirePc[s]),
                      64'(vecs[i].eRv[s] ? expPc(rd[s]) : 32'h0));
            end
        end

        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            setDisp(1'b1, 4'(2 * i), 6'(2 * i), 1'b1, 4'(2 * i + 1), 6'(2 * i + 1));
            tick();
        end
        idle();
        check("fill free", 64'(robFree), 64'h0);
        check("fill count", 64'(robCount), 64'd16);
        for (int i = 0; i < 9; i++) begin
            cv = (i < 8) ? 2'b11 : 2'b00;
            cn = {4'(2 * i + 1), 4'(2 * i)};
            tick();
            if (i == 0) begin
                check("drain first", 64'(retireValid), 64'h0);
            end else begin
                check($sformatf("drain%0d valid", i), 64'(retireValid), 64'h3);
                check($sformatf("drain%0d dest0", i), 64'(retireDestReg[0]), 64'(2 * (i - 1)));
                check($sformatf("drain%0d dest1", i), 64'(retireDestReg[1]), 64'(2 * i - 1));
                check($sformatf("drain%0d count", i), 64'(robCount), 64'(16 - 2 * i));
            end
        end
        idle();
        tick();
        check("drain end valid", 64'(retireValid), 64'h0);
        check("drain end free", 64'(robFree), 64'hFFFF);

        setDisp(1'b1, 4'd6, 6'd6, 1'b1, 4'd7, 6'd7);
        tick();
        idle();
        cv = 2'b11;
        cn = {4'd7, 4'd6};
        tick();
        cv = 2'b01;
        cn = {4'd0, 4'd7};
        tick();
        check("late complete retire", 64'(retireValid), 64'h3);
        check("late complete error", 64'(robError), 64'h0);
        check("late complete free", 64'(robFree), 64'hFFFF);
        idle();
        setDisp(1'b1, 4'd7, 6'd9, 1'b0, 4'd0, 6'd0);
        tick();
        idle();
        check("reuse 7 free", 64'(robFree), 64'hFF7F);
        tick();
        check("reuse 7 not done", 64'(retireValid), 64'h0);
        setDisp(1'b1, 4'd0, 6'd1, 1'b1, 4'd1, 6'd2);
        tick();
        setDisp(1'b1, 4'd2, 6'd3, 1'b1, 4'd3, 6'd4);
        tick();
        check("five busy count", 64'(robCount), 64'd5);
        reset = 1'b1;
        setDisp(1'b1, 4'd4, 6'd5, 1'b1, 4'd5, 6'd6);
        cv = 2'b01;
        cn = {4'd0, 4'd7};
        tick();
        reset = 1'b0;
        idle();
        check("mid reset free", 64'(robFree), 64'hFFFF);
        check("mid reset retire", 64'(retireValid), 64'h0);
        check("mid reset count", 64'(robCount), 64'h0);
        tick();
        check("post reset retire", 64'(retireValid), 64'h0);
        check("post reset regReady", retireRegReady, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: ROB_DEPTH, 16, entry count; fixed at 16 to match the 16-bit robFree vector and 4-bit robNum.
REQ-002 Parameter: PREG_COUNT, 64, physical register count; width of retireRegReady.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: robDispatch  in  robDispatchStruct  dual dispatch: valid1/2, destReg1/2 (6b), destRegOld1/2 (6b), robNum1/2 (4b), pc1/2 (32b); inst1 is older than inst2.
REQ-006 Port: completeValid  in  2  per-lane completion strobe.
REQ-007 Port: completeRobNum  in  2x4  ROB entry completed on each lane.
REQ-008 Port: robFree  out  16  bit i = 1 iff entry i is unallocated.
REQ-009 Port: retireRegReady  out  64  one-cycle pulse mask; bit destReg set per retired instruction.
REQ-010 Port: retireValid  out  2  per-slot retire strobe; slot 0 is older.
REQ-011 Port: retireDestReg / retireOldReg  out  2x6 each  retired destination; old mapping returned to free list.
REQ-012 Port: retirePc  out  2x32  retired PC (see REQ-029).
REQ-013 Port: robCount  out  5  allocated entries, 0..16.
REQ-014 Port: robError  out  1  sticky protocol-violation flag.

Function
REQ-015 Per entry: busy, done, destReg, destRegOld, pc; program order held in a 16-deep FIFO of 4-bit entry indices.
REQ-016 Dispatch lane k with validk=1 and robFree[robNumk]=1: set busy, clear done, store fields, push robNumk to the order FIFO; lane 1 is pushed before lane 2.
REQ-017 Dispatch to a busy entry, or valid1 and valid2 with equal robNum: the offending lane (lane 2 on collision) is dropped and robError is set.
REQ-018 Completion: completeValid[k] on a busy entry sets done at the next edge; completion of a non-busy entry is ignored and sets robError.
REQ-019 Retire: at each edge, if the head entry of the order FIFO has done=1, it retires in slot 0; head+1 retires in slot 1 only if slot 0 retires and head+1 has done=1. Strictly in order; at most 2 per cycle.
REQ-020 Retire outputs are registered: an entry whose done bit is set after edge E drives retireValid after edge E+1. Minimum completion-to-retire latency is 2 edges.
REQ-021 A retiring entry clears busy and done, and its robFree bit reads 1 after the retire edge.
REQ-022 Same-cycle dispatch and retire: dispatch sees only registered robFree; freed entries are usable from the next cycle.
REQ-023 Same-cycle completion and retire of one entry: done is registered first; no bypass into retire.
REQ-024 retireRegReady, retireValid, retireDestReg, retireOldReg and retirePc hold valid data only in the pulse cycle; unused slots drive 0.
REQ-025 robCount = previous count + dispatches accepted - retires, updated each edge; it never exceeds 16. Full means robFree = 0; empty means robCount = 0 and no retire.
REQ-026 Order FIFO pointers are 4 bits and wrap modulo 16, with a separate 5-bit occupancy count.

Reset
REQ-027 When reset=1 at an edge: all busy/done bits cleared, FIFO empty, robFree=16'hFFFF, robCount=0, retire outputs=0, retireRegReady=0, robError=0.
REQ-028 Reset overrides dispatch, complete and retire in the same cycle; reset mid-operation discards all in-flight entries.

Configuration
REQ-029 Macro ROB_RETIRE_PC_EN: when defined, pc is stored per entry and driven on retirePc. When undefined, no pc storage exists and retirePc is tied to 0. All other behaviour is identical.

Structure
REQ-030 Package typedefs: robDispatchStruct (existing), new robRetireStruct (valid, destReg, oldReg, pc per slot), constants ROB_DEPTH and PREG_COUNT.
REQ-031 Sub-module rob_order_fifo: dual-push/dual-pop 16x4 index FIFO exposing head, head+1 and count.

Verification
REQ-032 After reset: robFree=16'hFFFF, robCount=0, no retireValid, robError=0.
REQ-033 Dispatch robNum 15 (dest 5) and 14 (dest 6); complete 14, then 15 the next cycle: no retire until 15 is done, then both retire in the same cycle with retireRegReady bits 5 and 6 set; robFree[15:14] = 2'b11 after.
REQ-034 Fill all 16 entries: robFree=0 and robCount=16. Complete all entries; 8 consecutive cycles of dual retire follow, ending with robCount=0.
REQ-035 Dispatch with valid1 and valid2 both at robNum 3: only lane 1 is allocated and robError=1.
REQ-036 Drive completion on entry 7 in the same cycle as it retires elsewhere, and assert reset mid-stream with 5 entries busy: the next cycle shows robFree=16'hFFFF and no retire pulse.
REQ-037 With ROB_RETIRE_PC_EN defined, retirePc equals the dispatched pc (e.g. 32'h0000_0040); with it undefined, retirePc=0.
